// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem handshake, hazard/branch controls and the F/D load bundle.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        fd_wen;
  logic [15:0] instr_out;
  logic [15:0] oldpc_out;
  logic [15:0] newpc_out;
  logic        halted;

  modport master (
    input  stall, branch_taken, branch_target,
    input  imem_rdy, imem_data,
    output imem_req, imem_addr,
    output fd_wen, instr_out, oldpc_out, newpc_out,
    output halted
  );

  modport slave (
    output stall, branch_taken, branch_target,
    output imem_rdy, imem_data,
    input  imem_req, imem_addr,
    input  fd_wen, instr_out, oldpc_out, newpc_out,
    input  halted
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, fetches over a ready handshake, skids one word
// across a stall, applies branch redirects and freezes on HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    HALT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] pc_inc;
  logic        data_hlt;
  logic        buf_hlt;

  assign pc_inc   = pc_q + 16'd2;
  assign data_hlt = (bus.imem_data[15:12] == HALT_OPCODE);
  assign buf_hlt  = (buf_q[15:12] == HALT_OPCODE);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_d         = buf_q;
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc_q;
    bus.fd_wen    = 1'b0;
    bus.instr_out = NOP_INSTR;
    bus.oldpc_out = pc_q;
    bus.newpc_out = pc_inc;
    bus.halted    = 1'b0;

    if (!rst) begin
      bus.imem_req = (state_q == RUN);
      bus.halted   = (state_q == HALT);

      if (bus.branch_taken) begin
        // Flush the wrong-path word in F/D; any fetched or buffered word is dropped.
        bus.fd_wen = 1'b1;
        pc_d       = {bus.branch_target[15:1], 1'b0};
        state_d    = RUN;
      end else begin
        unique case (state_q)
          RUN: begin
            if (bus.imem_rdy) begin
              if (bus.stall) begin
                buf_d   = bus.imem_data;
                state_d = HOLD;
              end else begin
                bus.fd_wen    = 1'b1;
                bus.instr_out = bus.imem_data;
                if (data_hlt) begin
                  state_d = HALT;
                end else begin
                  pc_d = pc_inc;
                end
              end
            end
          end
          HOLD: begin
            if (!bus.stall) begin
              bus.fd_wen    = 1'b1;
              bus.instr_out = buf_q;
              if (buf_hlt) begin
                state_d = HALT;
              end else begin
                pc_d    = pc_inc;
                state_d = RUN;
              end
            end
          end
          HALT: begin
            state_d = HALT;
          end
          default: begin
            state_d = RUN;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule
